// File: rtl/image_pkg.sv
// Shared definitions for the capture and sender image paths:
// packing sizes, capture FSM states and the centred-window test.
package image_pkg;

    localparam int BYTE_SIZE          = 8;
    localparam int IMAGE_BUFFER_LEN   = 16;
    localparam int IMAGE_BUFFER_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        CAPTURE,
        DONE
    } capture_state_t;

    // One window definition so capture and sender agree on which pixels belong to the image.
    function automatic logic in_window(input int x, input int y,
                                       input int screen_width  = 1920,
                                       input int screen_height = 1080,
                                       input int image_width   = 100,
                                       input int image_height  = 100);
        return (y >  screen_height / 2 - image_height / 2) &&
               (y <= screen_height / 2 + image_height / 2) &&
               (x >  screen_width  / 2 - image_width  / 2) &&
               (x <= screen_width  / 2 + image_width  / 2);
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// Packs 8-bit pixels into 128-bit words, byte 0 in bits [7:0]; flush emits a
// zero-padded partial word.
module pixel_packer
    import image_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clear,
    input  logic [BYTE_SIZE-1:0]                   pixel,
    input  logic                                   valid,
    input  logic                                   flush,
    output logic [IMAGE_BUFFER_LEN*BYTE_SIZE-1:0]  word,
    output logic                                   word_valid
);

    logic [IMAGE_BUFFER_DEPTH-1:0]          index;
    logic [IMAGE_BUFFER_LEN*BYTE_SIZE-1:0]  buffer;
    logic [IMAGE_BUFFER_LEN*BYTE_SIZE-1:0]  merged;

    // Buffer is cleared after every word, so untouched upper bytes are already zero.
    always_comb begin
        merged = buffer;
        merged[index*BYTE_SIZE +: BYTE_SIZE] = pixel;
    end

    assign word       = merged;
    assign word_valid = valid &&
                        ((index == IMAGE_BUFFER_DEPTH'(IMAGE_BUFFER_LEN - 1)) || flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index  <= '0;
            buffer <= '0;
        end else if (clear) begin
            index  <= '0;
            buffer <= '0;
        end else if (valid) begin
            if (word_valid) begin
                index  <= '0;
                buffer <= '0;
            end else begin
                index  <= index + 1'b1;
                buffer <= merged;
            end
        end
    end

endmodule

// File: rtl/image_capture.sv
// Captures a centred window of one video frame as packed gray words for a capture FIFO.
// Define RGB_TO_GRAY_EN to use luma through an extra register stage instead of the blue channel.
module image_capture
    import image_pkg::*;
#(
    parameter int FRAME_WIDTH      = 2200,
    parameter int FRAME_HEIGHT     = 1125,
    parameter int SCREEN_WIDTH     = 1920,
    parameter int SCREEN_HEIGHT    = 1080,
    parameter int BIT_WIDTH        = 12,
    parameter int BIT_HEIGHT       = 11,
    parameter int IMAGE_WIDTH      = 100,
    parameter int IMAGE_HEIGHT     = 100,
    parameter int WORD_COUNT_WIDTH = 17
)
(
    input  logic                        pixel_clk,
    input  logic                        image_capture_reset_n,
    input  logic [BIT_WIDTH-1:0]        cx,
    input  logic [BIT_HEIGHT-1:0]       cy,
    input  logic [23:0]                 rgb_in,
    input  logic                        capture_arm,
    input  logic                        image_capture_full,
    output logic                        image_capture_write,
    output logic [127:0]                image_capture_fifo_dout,
    output logic                        capture_busy,
    output logic                        capture_done,
    output logic                        capture_overflow,
    output logic [WORD_COUNT_WIDTH-1:0] word_count
);

    localparam int LAST_X = SCREEN_WIDTH / 2 + IMAGE_WIDTH / 2;
    localparam int LAST_Y = SCREEN_HEIGHT / 2 + IMAGE_HEIGHT / 2;

    capture_state_t state;
    logic           frame_end;
    logic           win_now;
    logic           last_now;
    logic [7:0]     pix_byte;
    logic           win_sel;
    logic           last_sel;
    logic           pix_valid;
    logic           arm_accept;
    logic [127:0]   word;
    logic           word_valid;

    assign frame_end = (cx == BIT_WIDTH'(FRAME_WIDTH - 1)) && (cy == BIT_HEIGHT'(FRAME_HEIGHT - 1));
    assign win_now   = in_window(int'(cx), int'(cy), SCREEN_WIDTH, SCREEN_HEIGHT,
                                 IMAGE_WIDTH, IMAGE_HEIGHT);
    assign last_now  = (cx == BIT_WIDTH'(LAST_X)) && (cy == BIT_HEIGHT'(LAST_Y));

`ifdef RGB_TO_GRAY_EN
    logic [15:0] luma;
    logic [7:0]  gray_q;
    logic        win_q;
    logic        last_q;

    assign luma = 16'd77  * {8'd0, rgb_in[23:16]} +
                  16'd150 * {8'd0, rgb_in[15:8]}  +
                  16'd29  * {8'd0, rgb_in[7:0]};

    // Window flags travel with the luma so each byte keeps its own position.
    always_ff @(posedge pixel_clk or negedge image_capture_reset_n) begin
        if (!image_capture_reset_n) begin
            gray_q <= '0;
            win_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            gray_q <= 8'(luma >> 8);
            win_q  <= win_now;
            last_q <= last_now;
        end
    end

    assign pix_byte = gray_q;
    assign win_sel  = win_q;
    assign last_sel = last_q;
`else
    logic unused_rgb;
    assign unused_rgb = ^rgb_in[23:8];
    assign pix_byte   = rgb_in[7:0];
    assign win_sel    = win_now;
    assign last_sel   = last_now;
`endif

    assign pix_valid  = (state == CAPTURE) && win_sel;
    assign arm_accept = capture_arm && ((state == IDLE) || (state == DONE));

    pixel_packer u_packer (
        .clk        (pixel_clk),
        .rst_n      (image_capture_reset_n),
        .clear      (arm_accept),
        .pixel      (pix_byte),
        .valid      (pix_valid),
        .flush      (last_sel),
        .word       (word),
        .word_valid (word_valid)
    );

    // A word completing while the FIFO reports full is dropped; packing never stalls.
    always_ff @(posedge pixel_clk or negedge image_capture_reset_n) begin
        if (!image_capture_reset_n) begin
            state                   <= IDLE;
            image_capture_write     <= 1'b0;
            image_capture_fifo_dout <= '0;
            capture_busy            <= 1'b0;
            capture_done            <= 1'b0;
            capture_overflow        <= 1'b0;
            word_count              <= '0;
        end else begin
            image_capture_write <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (capture_arm) begin
                        state            <= WAIT_FRAME;
                        capture_busy     <= 1'b1;
                        capture_done     <= 1'b0;
                        capture_overflow <= 1'b0;
                        word_count       <= '0;
                    end
                end
                WAIT_FRAME: begin
                    if (frame_end) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (word_valid) begin
                        if (image_capture_full) begin
                            capture_overflow <= 1'b1;
                        end else begin
                            image_capture_write     <= 1'b1;
                            image_capture_fifo_dout <= word;
                            if (word_count != '1) begin
                                word_count <= word_count + 1'b1;
                            end
                        end
                    end
                    if (pix_valid && last_sel) begin
                        state        <= DONE;
                        capture_busy <= 1'b0;
                        capture_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_capture.sv
// Bench for image_capture: two instances (32x20 and 10x10 windows) on a shrunken video
// frame with random pixels, checked against a frame-level packing model.
`timescale 1ns/1ps
module tb_image_capture;

    localparam int FW = 64, FH = 48, SW = 48, SH = 40, BW = 12, BH = 11, WCW = 17;
    localparam int IW_A = 32, IH_A = 20, IW_B = 10, IH_B = 10;
    localparam int NPIX = FW * FH;
`ifdef RGB_TO_GRAY_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [BW-1:0]  cx = '0;
    logic [BH-1:0]  cy = '0;
    logic [23:0]    rgb = '0;
    logic           arm = 1'b0;
    logic           full_i [2];
    logic           write_o [2];
    logic [127:0]   dout_o [2];
    logic           busy_o [2];
    logic           done_o [2];
    logic           ovf_o [2];
    logic [WCW-1:0] wc_o [2];

    logic [7:0]     pix [2][$];
    int             cyc [2][$];
    bit             hist [2][NPIX+1];
    logic [127:0]   got [2][$];
    logic [127:0]   exp_w [2][$];
    int             exp_drop [2];
    logic [3:0]     snap_ctrl [2];
    logic [127:0]   snap_dout [2];
    logic [WCW-1:0] snap_wc [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    image_capture #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH),
                    .BIT_WIDTH(BW), .BIT_HEIGHT(BH), .IMAGE_WIDTH(IW_A), .IMAGE_HEIGHT(IH_A),
                    .WORD_COUNT_WIDTH(WCW)) dut_a (
        .pixel_clk(clk), .image_capture_reset_n(rst_n), .cx(cx), .cy(cy), .rgb_in(rgb),
        .capture_arm(arm), .image_capture_full(full_i[0]), .image_capture_write(write_o[0]),
        .image_capture_fifo_dout(dout_o[0]), .capture_busy(busy_o[0]), .capture_done(done_o[0]),
        .capture_overflow(ovf_o[0]), .word_count(wc_o[0]));

    image_capture #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH),
                    .BIT_WIDTH(BW), .BIT_HEIGHT(BH), .IMAGE_WIDTH(IW_B), .IMAGE_HEIGHT(IH_B),
                    .WORD_COUNT_WIDTH(WCW)) dut_b (
        .pixel_clk(clk), .image_capture_reset_n(rst_n), .cx(cx), .cy(cy), .rgb_in(rgb),
        .capture_arm(arm), .image_capture_full(full_i[1]), .image_capture_write(write_o[1]),
        .image_capture_fifo_dout(dout_o[1]), .capture_busy(busy_o[1]), .capture_done(done_o[1]),
        .capture_overflow(ovf_o[1]), .word_count(wc_o[1]));

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (write_o[k]) got[k].push_back(dout_o[k]);
        end
    end

    function automatic bit in_win_ref(input int x, input int y, input int iw, input int ih);
        return (y > SH/2 - ih/2) && (y <= SH/2 + ih/2) && (x > SW/2 - iw/2) && (x <= SW/2 + iw/2);
    endfunction

    function automatic logic [7:0] gray_of(input logic [23:0] p);
`ifdef RGB_TO_GRAY_EN
        int s;
        s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
        return 8'(s / 256);
`else
        return p[7:0];
`endif
    endfunction

    // Chunk the captured pixels 16 at a time; a word is lost if full was high when it completed.
    function automatic void build_exp(input int k);
        int n, last;
        logic [127:0] w;
        n = pix[k].size();
        exp_w[k].delete();
        exp_drop[k] = 0;
        for (int i = 0; i * 16 < n; i++) begin
            w = '0;
            for (int b = 0; b < 16; b++) begin
                if (i * 16 + b < n) w[b*8 +: 8] = pix[k][i*16 + b];
            end
            last = (i * 16 + 15 < n) ? i * 16 + 15 : n - 1;
            if (hist[k][cyc[k][last] + LAT]) exp_drop[k]++;
            else exp_w[k].push_back(w);
        end
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            pix[k].delete();
            cyc[k].delete();
            got[k].delete();
        end
    endtask

    task automatic drive_frame(input bit cap_a, input bit cap_b, input int arm_cyc, input bit ramp,
                               input int full_lo, input int full_hi, input bit rnd_full_b,
                               input int rst_cyc);
        int  c, ord_a;
        bit  ca, cb;
        ca = cap_a;
        cb = cap_b;
        ord_a = 0;
        for (int i = 0; i <= NPIX; i++) begin
            hist[0][i] = 1'b0;
            hist[1][i] = 1'b0;
        end
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < FW; x++) begin
                @(negedge clk);
                c = y * FW + x;
                cx = BW'(x);
                cy = BH'(y);
                rgb = ramp ? {16'($urandom), 8'(x)} : 24'($urandom);
                arm = (c == arm_cyc);
                full_i[0] = ca && (ord_a >= full_lo) && (ord_a < full_hi);
                full_i[1] = cb && rnd_full_b && ($urandom_range(0, 3) == 0);
                hist[0][c] = full_i[0];
                hist[1][c] = full_i[1];
                if (ca && in_win_ref(x, y, IW_A, IH_A)) begin
                    pix[0].push_back(gray_of(rgb));
                    cyc[0].push_back(c);
                    ord_a++;
                end
                if (cb && in_win_ref(x, y, IW_B, IH_B)) begin
                    pix[1].push_back(gray_of(rgb));
                    cyc[1].push_back(c);
                end
                if (c == rst_cyc) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    for (int k = 0; k < 2; k++) begin
                        snap_ctrl[k] = {write_o[k], busy_o[k], done_o[k], ovf_o[k]};
                        snap_dout[k] = dout_o[k];
                        snap_wc[k]   = wc_o[k];
                    end
                    rst_n = 1'b1;
                    ca = 1'b0;
                    cb = 1'b0;
                    clear_model();
                end
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks += 6;
            if (write_o[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_write[%0d]: got %b want 0", k, write_o[k]); end
            if (dout_o[k] !== '0) begin errors++; $display("[TB] FAIL reset_dout[%0d]: got %h want 0", k, dout_o[k]); end
            if (busy_o[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy[%0d]: got %b want 0", k, busy_o[k]); end
            if (done_o[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_done[%0d]: got %b want 0", k, done_o[k]); end
            if (ovf_o[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf[%0d]: got %b want 0", k, ovf_o[k]); end
            if (wc_o[k] !== '0) begin errors++; $display("[TB] FAIL reset_wc[%0d]: got %0d want 0", k, wc_o[k]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ramp_capture();
        drive_frame(0, 0, 100, 1, 0, 0, 0, -1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy_o[k] !== 1'b1) begin errors++; $display("[TB] FAIL ramp_armed_busy[%0d]: got %b want 1", k, busy_o[k]); end
        end
        clear_model();
        drive_frame(1, 1, -1, 1, 0, 0, 0, -1);
        for (int k = 0; k < 2; k++) begin
            build_exp(k);
            checks += 5;
            if (got[k].size() !== exp_w[k].size()) begin errors++; $display("[TB] FAIL ramp_writes[%0d]: got %0d want %0d", k, got[k].size(), exp_w[k].size()); end
            if (wc_o[k] !== WCW'(exp_w[k].size())) begin errors++; $display("[TB] FAIL ramp_wc[%0d]: got %0d want %0d", k, wc_o[k], exp_w[k].size()); end
            if (ovf_o[k] !== 1'b0) begin errors++; $display("[TB] FAIL ramp_ovf[%0d]: got %b want 0", k, ovf_o[k]); end
            if (done_o[k] !== 1'b1) begin errors++; $display("[TB] FAIL ramp_done[%0d]: got %b want 1", k, done_o[k]); end
            if (busy_o[k] !== 1'b0) begin errors++; $display("[TB] FAIL ramp_busy[%0d]: got %b want 0", k, busy_o[k]); end
            for (int i = 0; i < got[k].size() && i < exp_w[k].size(); i++) begin
                checks++;
                if (got[k][i] !== exp_w[k][i]) begin errors++; $display("[TB] FAIL ramp_word[%0d][%0d]: got %h want %h", k, i, got[k][i], exp_w[k][i]); end
            end
        end
        checks++;
        if (wc_o[1] !== WCW'(7)) begin errors++; $display("[TB] FAIL small_wc: got %0d want 7", wc_o[1]); end
        if (got[1].size() == 7) begin
            checks++;
            if (got[1][6][127:32] !== 96'd0) begin errors++; $display("[TB] FAIL small_pad: got %h want 0", got[1][6][127:32]); end
        end
`ifndef RGB_TO_GRAY_EN
        if (got[0].size() > 0) begin
            checks += 2;
            if (got[0][0][7:0] !== 8'h09) begin errors++; $display("[TB] FAIL ramp_byte0: got %h want 09", got[0][0][7:0]); end
            if (got[0][0][127:120] !== 8'h18) begin errors++; $display("[TB] FAIL ramp_byte15: got %h want 18", got[0][0][127:120]); end
        end
`endif
    endtask

    task automatic test_overflow();
        drive_frame(0, 0, 100, 0, 0, 0, 0, -1);
        checks += 2;
        if (wc_o[0] !== '0) begin errors++; $display("[TB] FAIL rearm_wc: got %0d want 0", wc_o[0]); end
        if (busy_o[0] !== 1'b1) begin errors++; $display("[TB] FAIL rearm_busy: got %b want 1", busy_o[0]); end
        clear_model();
        drive_frame(1, 1, -1, 0, 160, 320, 1, -1);
        for (int k = 0; k < 2; k++) begin
            build_exp(k);
            checks += 3;
            if (got[k].size() !== exp_w[k].size()) begin errors++; $display("[TB] FAIL ovf_writes[%0d]: got %0d want %0d", k, got[k].size(), exp_w[k].size()); end
            if (wc_o[k] !== WCW'(exp_w[k].size())) begin errors++; $display("[TB] FAIL ovf_wc[%0d]: got %0d want %0d", k, wc_o[k], exp_w[k].size()); end
            if (ovf_o[k] !== (exp_drop[k] > 0)) begin errors++; $display("[TB] FAIL ovf_flag[%0d]: got %b want %b", k, ovf_o[k], exp_drop[k] > 0); end
            for (int i = 0; i < got[k].size() && i < exp_w[k].size(); i++) begin
                checks++;
                if (got[k][i] !== exp_w[k][i]) begin errors++; $display("[TB] FAIL ovf_word[%0d][%0d]: got %h want %h", k, i, got[k][i], exp_w[k][i]); end
            end
        end
`ifndef RGB_TO_GRAY_EN
        checks++;
        if (wc_o[0] !== WCW'(30)) begin errors++; $display("[TB] FAIL ovf_ten_dropped: got %0d want 30", wc_o[0]); end
`endif
        drive_frame(0, 0, -1, 0, 0, 0, 0, -1);
        checks++;
        if (ovf_o[0] !== (exp_drop[0] > 0)) begin errors++; $display("[TB] FAIL ovf_sticky: got %b want %b", ovf_o[0], exp_drop[0] > 0); end
    endtask

    task automatic test_arm_ignored();
        int n0, n1;
        drive_frame(0, 0, 100, 0, 0, 0, 0, -1);
        checks += 2;
        if (ovf_o[0] !== 1'b0) begin errors++; $display("[TB] FAIL arm_clears_ovf: got %b want 0", ovf_o[0]); end
        if (done_o[0] !== 1'b0) begin errors++; $display("[TB] FAIL arm_clears_done: got %b want 0", done_o[0]); end
        clear_model();
        drive_frame(1, 1, 20 * FW + 5, 0, 0, 0, 0, -1);
        for (int k = 0; k < 2; k++) begin
            build_exp(k);
            checks += 2;
            if (got[k].size() !== exp_w[k].size()) begin errors++; $display("[TB] FAIL ign_writes[%0d]: got %0d want %0d", k, got[k].size(), exp_w[k].size()); end
            if (wc_o[k] !== WCW'(exp_w[k].size())) begin errors++; $display("[TB] FAIL ign_wc[%0d]: got %0d want %0d", k, wc_o[k], exp_w[k].size()); end
            for (int i = 0; i < got[k].size() && i < exp_w[k].size(); i++) begin
                checks++;
                if (got[k][i] !== exp_w[k][i]) begin errors++; $display("[TB] FAIL ign_word[%0d][%0d]: got %h want %h", k, i, got[k][i], exp_w[k][i]); end
            end
        end
        n0 = got[0].size();
        n1 = got[1].size();
        drive_frame(0, 0, -1, 0, 0, 0, 0, -1);
        checks += 4;
        if (got[0].size() !== n0) begin errors++; $display("[TB] FAIL ign_single_a: got %0d want %0d", got[0].size(), n0); end
        if (got[1].size() !== n1) begin errors++; $display("[TB] FAIL ign_single_b: got %0d want %0d", got[1].size(), n1); end
        if (done_o[0] !== 1'b1) begin errors++; $display("[TB] FAIL ign_done: got %b want 1", done_o[0]); end
        if (busy_o[0] !== 1'b0) begin errors++; $display("[TB] FAIL ign_busy: got %b want 0", busy_o[0]); end
    endtask

    task automatic test_reset_mid_capture();
        drive_frame(0, 0, 100, 0, 0, 0, 0, -1);
        clear_model();
        drive_frame(1, 1, -1, 0, 0, 0, 0, 15 * FW + 20);
        for (int k = 0; k < 2; k++) begin
            checks += 3;
            if (snap_ctrl[k] !== 4'b0) begin errors++; $display("[TB] FAIL midrst_ctrl[%0d]: got %b want 0000", k, snap_ctrl[k]); end
            if (snap_dout[k] !== '0) begin errors++; $display("[TB] FAIL midrst_dout[%0d]: got %h want 0", k, snap_dout[k]); end
            if (snap_wc[k] !== '0) begin errors++; $display("[TB] FAIL midrst_wc[%0d]: got %0d want 0", k, snap_wc[k]); end
        end
        drive_frame(0, 0, -1, 0, 0, 0, 0, -1);
        for (int k = 0; k < 2; k++) begin
            checks += 4;
            if (got[k].size() !== 0) begin errors++; $display("[TB] FAIL midrst_nowrite[%0d]: got %0d want 0", k, got[k].size()); end
            if (busy_o[k] !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy[%0d]: got %b want 0", k, busy_o[k]); end
            if (done_o[k] !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done[%0d]: got %b want 0", k, done_o[k]); end
            if (wc_o[k] !== '0) begin errors++; $display("[TB] FAIL midrst_wc_after[%0d]: got %0d want 0", k, wc_o[k]); end
        end
    endtask

    initial begin
        full_i[0] = 1'b0;
        full_i[1] = 1'b0;
        test_reset();
        test_ramp_capture();
        test_overflow();
        test_arm_ignored();
        test_reset_mid_capture();
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
